// File: rtl/mic_arrival_qualifier_if.sv
// -----------------------------------------------------------------------------
// mic_arrival_qualifier_if
//
// Purpose : groups the comparator-sample inputs, the shot controls and the
//           arrival results exchanged between the microphone front end and
//           the time-of-flight logic.
//
// Signals :
//   mic_in      [3:0]  registered comparator samples ([0]=N [1]=E [2]=S [3]=W)
//   arm                single-cycle pulse, start a shot
//   abort              single-cycle pulse, cancel the shot and clear results
//   arrived     [3:0]  sticky per-channel arrival flags
//   first_valid        |arrived
//   order       [7:0]  order[2k+1:2k] = channel index of the k-th arrival
//   n_arrived   [2:0]  channels arrived so far, 0..4
//   done               one-cycle pulse, all four channels arrived
//   timeout            sticky, shot ended by timeout
//   state       [1:0]  FSM state for the debug mux
//
// Modports: master drives samples/controls, slave (the qualifier) drives
//           the results.
// -----------------------------------------------------------------------------
interface mic_arrival_qualifier_if;
   logic [3:0] mic_in;
   logic       arm;
   logic       abort;
   logic [3:0] arrived;
   logic       first_valid;
   logic [7:0] order;
   logic [2:0] n_arrived;
   logic       done;
   logic       timeout;
   logic [1:0] state;

   modport master (
      output mic_in, arm, abort,
      input  arrived, first_valid, order, n_arrived, done, timeout, state
   );

   modport slave (
      input  mic_in, arm, abort,
      output arrived, first_valid, order, n_arrived, done, timeout, state
   );
endinterface

// File: rtl/mic_arrival_qualifier.sv
// -----------------------------------------------------------------------------
// mic_arrival_qualifier
//
// Purpose : qualifies the four microphone comparator streams, latches the
//           first qualified arrival per channel into sticky flags, records
//           the arrival order and ends a shot when all four channels have
//           arrived or when the timeout after the first arrival expires.
//
// Ports   :
//   clk64M  in   sample clock (single domain)
//   reset   in   synchronous, active-high reset
//   bus     slave modport of mic_arrival_qualifier_if (samples, arm/abort,
//           arrival flags, order, count, done, timeout, state)
//
// Parameters:
//   FILT_LEN     consecutive high samples that qualify an arrival (2..15)
//   TIMEOUT_CYC  cycles allowed from first to fourth arrival
//   TW           timer width, derived from TIMEOUT_CYC; do not override
//
// Build option:
//   MIC_GLITCH_FILT_EN  defined   -> per-channel glitch filter, latency FILT_LEN
//                       undefined -> no filter, a channel qualifies on its
//                                    first high sample (latency 1)
// -----------------------------------------------------------------------------
module mic_arrival_qualifier #(
   parameter int FILT_LEN    = 4,
   parameter int TIMEOUT_CYC = 4096,
   parameter int TW          = $clog2(TIMEOUT_CYC)
) (
   input logic                    clk64M,
   input logic                    reset,
   mic_arrival_qualifier_if.slave bus
);

   if (FILT_LEN < 2 || FILT_LEN > 15) begin : g_filt_len_check
      $error("mic_arrival_qualifier: FILT_LEN must be within 2..15");
   end

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      ARMED   = 2'b01,
      CAPTURE = 2'b10,
      FINISH  = 2'b11
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    arrived_q, arrived_d;
   logic [7:0]    order_q, order_d;
   logic [2:0]    n_q, n_d;
   logic          done_q, done_d;
   logic          timeout_q, timeout_d;
   logic [TW-1:0] timer_q, timer_d;

   logic          sampling;   // filters/arrivals only live in ARMED/CAPTURE
   logic [3:0]    qual;       // channels qualifying this cycle
   logic [3:0]    arr_upd;    // arrived flags including this cycle's arrivals
   logic [7:0]    order_upd;  // order including this cycle's arrivals
   logic [2:0]    n_upd;      // arrival count including this cycle's arrivals

   assign sampling = (state_q == ARMED || state_q == CAPTURE) && !bus.abort;

`ifdef MIC_GLITCH_FILT_EN
   logic [3:0][3:0] filt_q, filt_d;

   // Qualification looks at the incremented count so that a run starting
   // with the sample taken at edge t sets arrived at edge t+FILT_LEN-1,
   // making the flag visible FILT_LEN cycles after the run starts.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
         filt_d[i] = 4'd0;
         qual[i]   = 1'b0;
         if (sampling && bus.mic_in[i]) begin
            filt_d[i] = (filt_q[i] == 4'(FILT_LEN)) ? filt_q[i] : filt_q[i] + 4'd1;
            qual[i]   = (filt_d[i] == 4'(FILT_LEN)) && !arrived_q[i];
         end
      end
   end

   always_ff @(posedge clk64M) begin
      if (reset) filt_q <= '0;
      else       filt_q <= filt_d;
   end
`else
   always_comb begin
      qual = sampling ? (bus.mic_in & ~arrived_q) : 4'b0000;
   end
`endif

   // Rank this cycle's qualifiers in ascending channel index (north first).
   always_comb begin
      arr_upd   = arrived_q;
      order_upd = order_q;
      n_upd     = n_q;
      for (int i = 0; i < 4; i++) begin
         if (qual[i]) begin
            arr_upd[i]                      = 1'b1;
            order_upd[2*int'(n_upd[1:0]) +: 2] = 2'(i);
            n_upd                           = n_upd + 3'd1;
         end
      end
   end

   // Next-state and result logic.
   always_comb begin
      state_d   = state_q;
      arrived_d = arrived_q;
      order_d   = order_q;
      n_d       = n_q;
      done_d    = 1'b0;
      timeout_d = timeout_q;
      timer_d   = timer_q;

      case (state_q)
         IDLE: begin
            if (bus.arm) begin
               state_d   = ARMED;
               arrived_d = '0;
               order_d   = '0;
               n_d       = '0;
               timeout_d = 1'b0;
               timer_d   = '0;
            end
         end
         ARMED: begin
            arrived_d = arr_upd;
            order_d   = order_upd;
            n_d       = n_upd;
            if (qual != 4'b0000) begin
               timer_d = '0;
               // Four simultaneous first arrivals complete the shot at once.
               if (n_upd == 3'd4) begin
                  state_d = FINISH;
                  done_d  = 1'b1;
               end else begin
                  state_d = CAPTURE;
               end
            end
         end
         CAPTURE: begin
            arrived_d = arr_upd;
            order_d   = order_upd;
            n_d       = n_upd;
            timer_d   = timer_q + 1'b1;
            // Completion has priority over a timeout in the same cycle.
            if (n_upd == 3'd4) begin
               state_d = FINISH;
               done_d  = 1'b1;
            end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
               state_d   = FINISH;
               timeout_d = 1'b1;
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Abort overrides everything, including an arm in the same cycle.
      if (bus.abort) begin
         state_d   = IDLE;
         arrived_d = '0;
         order_d   = '0;
         n_d       = '0;
         done_d    = 1'b0;
         timeout_d = 1'b0;
         timer_d   = '0;
      end
   end

   // NOTE: state is updated with non-blocking assignments so every register samples the pre-edge values of the others.
   always_ff @(posedge clk64M) begin
      // NOTE: reset is synchronous and clears every register here, since results must read 0 one cycle after reset.
      if (reset) begin
         state_q   <= IDLE;
         arrived_q <= '0;
         order_q   <= '0;
         n_q       <= '0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         timer_q   <= '0;
      end else begin
         state_q   <= state_d;
         arrived_q <= arrived_d;
         order_q   <= order_d;
         n_q       <= n_d;
         done_q    <= done_d;
         timeout_q <= timeout_d;
         timer_q   <= timer_d;
      end
   end

   assign bus.arrived     = arrived_q;
   assign bus.first_valid = |arrived_q;
   assign bus.order       = order_q;
   assign bus.n_arrived   = n_q;
   assign bus.done        = done_q;
   assign bus.timeout     = timeout_q;
   assign bus.state       = state_q;

endmodule
